// File: rtl/dds_param_ctrl.sv
// ---------------------------------------------------------------------------
// dds_param_ctrl
//
// Front-panel configuration controller for the DDS signal generator.
// Four raw push-buttons are synchronised, debounced and turned into one-cycle
// press events. An edit-field state machine (WAVE -> FREQ -> AMP) applies
// those events to the live waveform parameters. cfg_upd tells the DDS core
// and the display block to reload.
//
// Ports:
//   clk        in   1   system clock, the only clock
//   rst        in   1   synchronous reset, active-high
//   key        in   4   raw buttons, active-low, asynchronous
//                       [0]=mode [1]=up [2]=down [3]=step
//   wave_sel   out  2   0 sine, 1 square, 2 triangle, 3 sawtooth
//   wave_freq  out  20  output frequency in Hz, FREQ_MIN..FREQ_MAX
//   wave_a     out  2   amplitude code 0..3
//   edit_field out  2   0 WAVE, 1 FREQ, 2 AMP (display cursor)
//   step_idx   out  3   frequency step exponent 0..5, step = 10^step_idx
//   cfg_upd    out  1   one-cycle pulse when wave_sel/wave_freq/wave_a change
//
// Optional feature (macro DDS_KEY_AUTO_REPEAT_EN):
//   Holding up or down issues a synthetic press REP_DLY cycles after the
//   real press, then one every REP_PER cycles until the key is released.
//   Without the macro every physical press yields exactly one event.
//
// Latency: a clean raw falling edge updates the outputs DEB_CNT+3 edges later
// (2 sync flops, DEB_CNT-1 stable samples, press pulse register, output
// register).
// ---------------------------------------------------------------------------
module dds_param_ctrl #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int FREQ_MIN = 1,
  parameter int FREQ_MAX = 999_999,
  parameter int FREQ_RST = 1000,
  parameter int REP_DLY  = 25_000_000,
  parameter int REP_PER  = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key,
  output logic [1:0]  wave_sel,
  output logic [19:0] wave_freq,
  output logic [1:0]  wave_a,
  output logic [1:0]  edit_field,
  output logic [2:0]  step_idx,
  output logic        cfg_upd
);

  localparam int          DEB_W = $clog2(DEB_CNT + 1);
  localparam logic [20:0] FMAX  = 21'(FREQ_MAX);
  localparam logic [20:0] FMIN  = 21'(FREQ_MIN);
  localparam logic [19:0] FRST  = 20'(FREQ_RST);

  typedef enum logic [1:0] {
    F_WAVE = 2'd0,
    F_FREQ = 2'd1,
    F_AMP  = 2'd2
  } field_e;

  // Key bit positions
  localparam int K_MODE = 0;
  localparam int K_UP   = 1;
  localparam int K_DOWN = 2;
  localparam int K_STEP = 3;

  // -------------------------------------------------------------------------
  // Input synchronisers (idle level of an active-low key is 1)
  // -------------------------------------------------------------------------
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  // NOTE: clocked state is always assigned with <= so every flop samples the
  // pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: the counter tracks how long the synced level has disagreed
  // with the debounced level; the DEB_CNT-1'th consecutive disagreeing sample
  // flips the debounced level.
  // -------------------------------------------------------------------------
  logic [DEB_W-1:0] r_deb_cnt [4];
  logic [3:0]       r_deb;
  logic [3:0]       r_deb_d;
  logic [3:0]       r_press;

  // NOTE: the four counters are individual flops, not a RAM, so each element
  // is cleared by the reset loop; a real memory array would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
      r_deb <= '1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (int'(r_deb_cnt[i]) + 1 >= DEB_CNT - 1) begin
            r_deb[i]     <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Press = debounced 1->0, registered as a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_deb_d <= '1;
      r_press <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
    end
  end

  // -------------------------------------------------------------------------
  // Event source: real presses, optionally merged with auto-repeat pulses
  // -------------------------------------------------------------------------
  logic [3:0] w_evt;

`ifdef DDS_KEY_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_hold_act;   // a hold of up/down is being timed
  logic              r_hold_dn;    // 0: holding up, 1: holding down
  logic              r_hold_per;   // 0: waiting REP_DLY, 1: repeating at REP_PER
  logic [3:0]        r_rep;
  logic              w_hold_lvl;
  logic [HOLD_W-1:0] w_hold_nxt;
  int                w_hold_lim;

  assign w_hold_lvl = r_hold_dn ? r_deb[K_DOWN] : r_deb[K_UP];
  assign w_hold_nxt = r_hold_cnt + HOLD_W'(1);
  assign w_hold_lim = r_hold_per ? REP_PER : REP_DLY;

  // The press edge loads the counter with 1 (the press cycle itself counts)
  // while a repeat edge loads 0, so both phases fire on reaching their limit
  // and the synthetic events land exactly REP_DLY / REP_PER cycles apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_hold_act <= 1'b0;
      r_hold_dn  <= 1'b0;
      r_hold_per <= 1'b0;
      r_rep      <= '0;
    end else begin
      r_rep <= '0;
      if (r_press[K_UP] || r_press[K_DOWN]) begin
        r_hold_act <= 1'b1;
        r_hold_dn  <= ~r_press[K_UP];
        r_hold_per <= 1'b0;
        r_hold_cnt <= HOLD_W'(1);
      end else if (r_hold_act) begin
        if (w_hold_lvl) begin
          r_hold_act <= 1'b0;
          r_hold_cnt <= '0;
        end else if (r_press[K_MODE]) begin
          // Mode during a hold restarts the initial delay.
          r_hold_per <= 1'b0;
          r_hold_cnt <= '0;
        end else if (int'(w_hold_nxt) >= w_hold_lim) begin
          r_rep      <= r_hold_dn ? 4'b0100 : 4'b0010;
          r_hold_per <= 1'b1;
          r_hold_cnt <= '0;
        end else begin
          r_hold_cnt <= w_hold_nxt;
        end
      end
    end
  end

  assign w_evt = r_press | r_rep;
`else
  logic w_unused_rep;

  assign w_unused_rep = REP_DLY[0] ^ REP_PER[0];
  assign w_evt        = r_press;
`endif

  // Priority mode > step > up > down; lower events in the same cycle drop.
  logic w_mode;
  logic w_step;
  logic w_up;
  logic w_down;

  assign w_mode = w_evt[K_MODE];
  assign w_step = w_evt[K_STEP] & ~w_mode;
  assign w_up   = w_evt[K_UP]   & ~w_mode & ~w_evt[K_STEP];
  assign w_down = w_evt[K_DOWN] & ~w_mode & ~w_evt[K_STEP] & ~w_evt[K_UP];

  // -------------------------------------------------------------------------
  // Edit-field FSM and parameter registers
  // -------------------------------------------------------------------------
  field_e      r_field;
  logic [1:0]  r_sel;
  logic [19:0] r_freq;
  logic [1:0]  r_a;
  logic [2:0]  r_step;
  logic        r_upd;

  field_e      w_field_nxt;
  logic [1:0]  w_sel_nxt;
  logic [19:0] w_freq_nxt;
  logic [1:0]  w_a_nxt;
  logic [2:0]  w_step_nxt;
  logic        w_upd_nxt;
  logic [20:0] w_step_val;
  logic [20:0] w_sum;
  logic [20:0] w_diff;

  function automatic logic [20:0] pow10(input logic [2:0] idx);
    case (idx)
      3'd0:    pow10 = 21'd1;
      3'd1:    pow10 = 21'd10;
      3'd2:    pow10 = 21'd100;
      3'd3:    pow10 = 21'd1000;
      3'd4:    pow10 = 21'd10000;
      3'd5:    pow10 = 21'd100000;
      default: pow10 = 21'd1;
    endcase
  endfunction

  // 21-bit arithmetic: the sum cannot wrap, and a negative difference shows
  // up as bit 20 set, so both saturations are plain compares.
  assign w_step_val = pow10(r_step);
  assign w_sum      = {1'b0, r_freq} + w_step_val;
  assign w_diff     = {1'b0, r_freq} - w_step_val;

  always_ff @(posedge clk) begin
    if (rst) r_field <= F_WAVE;
    else     r_field <= w_field_nxt;
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_field_nxt = r_field;
    w_sel_nxt   = r_sel;
    w_freq_nxt  = r_freq;
    w_a_nxt     = r_a;
    w_step_nxt  = r_step;

    if (w_mode) begin
      case (r_field)
        F_WAVE:  w_field_nxt = F_FREQ;
        F_FREQ:  w_field_nxt = F_AMP;
        default: w_field_nxt = F_WAVE;
      endcase
    end else begin
      case (r_field)
        F_WAVE: begin
          if (w_up)        w_sel_nxt = r_sel + 2'd1;
          else if (w_down) w_sel_nxt = r_sel - 2'd1;
        end
        F_FREQ: begin
          if (w_step) begin
            w_step_nxt = (r_step >= 3'd5) ? 3'd0 : r_step + 3'd1;
          end else if (w_up) begin
            w_freq_nxt = (w_sum > FMAX) ? FMAX[19:0] : w_sum[19:0];
          end else if (w_down) begin
            w_freq_nxt = (w_diff[20] || (w_diff < FMIN)) ? FMIN[19:0] : w_diff[19:0];
          end
        end
        F_AMP: begin
          if (w_up && (r_a != 2'd3))        w_a_nxt = r_a + 2'd1;
          else if (w_down && (r_a != 2'd0)) w_a_nxt = r_a - 2'd1;
        end
        default: w_field_nxt = F_WAVE;
      endcase
    end

    w_upd_nxt = (w_sel_nxt != r_sel) || (w_freq_nxt != r_freq) || (w_a_nxt != r_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= 2'd0;
      r_freq <= FRST;
      r_a    <= 2'd0;
      r_step <= 3'd0;
      r_upd  <= 1'b0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_freq <= w_freq_nxt;
      r_a    <= w_a_nxt;
      r_step <= w_step_nxt;
      r_upd  <= w_upd_nxt;
    end
  end

  assign wave_sel   = r_sel;
  assign wave_freq  = r_freq;
  assign wave_a     = r_a;
  assign edit_field = r_field;
  assign step_idx   = r_step;
  assign cfg_upd    = r_upd;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_param_ctrl
//
// Self-checking bench for dds_param_ctrl with DEB_CNT=4, REP_DLY=40,
// REP_PER=10. Each button press pushes the expected post-press state onto a
// scoreboard queue; the entry is popped and compared on the edge where the
// DUT must present the new values (DEB_CNT+3 edges after the raw edge).
// Honours DDS_KEY_AUTO_REPEAT_EN for the hold test.
// ---------------------------------------------------------------------------
module tb_dds_param_ctrl;

  localparam int DEB_CNT = 4;
  localparam int REP_DLY = 40;
  localparam int REP_PER = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic [1:0]  wave_sel;
  logic [19:0] wave_freq;
  logic [1:0]  wave_a;
  logic [1:0]  edit_field;
  logic [2:0]  step_idx;
  logic        cfg_upd;

  dds_param_ctrl #(
    .DEB_CNT (DEB_CNT),
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .wave_sel   (wave_sel),
    .wave_freq  (wave_freq),
    .wave_a     (wave_a),
    .edit_field (edit_field),
    .step_idx   (step_idx),
    .cfg_upd    (cfg_upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [19:0] freq;
    logic [1:0]  a;
    logic [1:0]  field;
    logic [2:0]  step;
    logic        upd;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;

  // Keys as a press mask (1 = pressed)
  localparam logic [3:0] MODE = 4'b0001;
  localparam logic [3:0] UP   = 4'b0010;
  localparam logic [3:0] DOWN = 4'b0100;
  localparam logic [3:0] STEP = 4'b1000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] sel, input logic [19:0] freq,
                              input logic [1:0] a, input logic [1:0] field,
                              input logic [2:0] step, input logic upd);
    exp_t e;
    e.sel = sel; e.freq = freq; e.a = a; e.field = field; e.step = step; e.upd = upd;
    return e;
  endfunction

  task automatic check_state(input string tag, input exp_t e);
    check({tag, "_sel"},   32'(wave_sel),   32'(e.sel));
    check({tag, "_freq"},  32'(wave_freq),  32'(e.freq));
    check({tag, "_amp"},   32'(wave_a),     32'(e.a));
    check({tag, "_field"}, 32'(edit_field), 32'(e.field));
    check({tag, "_step"},  32'(step_idx),   32'(e.step));
    check({tag, "_upd"},   32'(cfg_upd),    32'(e.upd));
  endtask

  // Clean press: raw edge just after an edge (cycle 0), held 20 cycles.
  task automatic press(input string tag, input logic [3:0] keys, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    @(posedge clk); #1 key = ~keys;
    repeat (DEB_CNT + 2) @(posedge clk);
    #1 check({tag, "_early_upd"}, 32'(cfg_upd), 32'd0);
    @(posedge clk); #1;
    check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_state(tag, x);
    end
    @(posedge clk); #1 check({tag, "_upd_end"}, 32'(cfg_upd), 32'd0);
    repeat (12) @(posedge clk);
    #1 key = '1;
    repeat (12) @(posedge clk);
  endtask

  int   exp_hold;
  int   freq_after_hold;

  initial begin
    rst = 1'b1;
    key = '1;
    repeat (3) @(posedge clk);
    #1 check_state("in_rst", mk(2'd0, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b0));
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1 check_state("idle", mk(2'd0, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b0));
    end

    // WAVE: up four times wraps 3->0
    press("w_up1", UP, mk(2'd1, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b1));
    press("w_up2", UP, mk(2'd2, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b1));
    press("w_up3", UP, mk(2'd3, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b1));
    press("w_up4", UP, mk(2'd0, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b1));

    // Bounce: up toggles every 2 cycles for 30 cycles, must never register
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      key[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) begin
        @(posedge clk); #1 check("bounce_upd", 32'(cfg_upd), 32'd0);
      end
    end
    key = '1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 check("bounce_upd", 32'(cfg_upd), 32'd0);
    end
    check("bounce_sel", 32'(wave_sel), 32'd0);

    // FREQ field
    press("mode_freq", MODE, mk(2'd0, 20'd1000,   2'd0, 2'd1, 3'd0, 1'b0));
    press("f_step1",   STEP, mk(2'd0, 20'd1000,   2'd0, 2'd1, 3'd1, 1'b0));
    press("f_step2",   STEP, mk(2'd0, 20'd1000,   2'd0, 2'd1, 3'd2, 1'b0));
    press("f_step3",   STEP, mk(2'd0, 20'd1000,   2'd0, 2'd1, 3'd3, 1'b0));
    press("f_up1",     UP,   mk(2'd0, 20'd2000,   2'd0, 2'd1, 3'd3, 1'b1));
    press("f_up2",     UP,   mk(2'd0, 20'd3000,   2'd0, 2'd1, 3'd3, 1'b1));
    press("f_up3",     UP,   mk(2'd0, 20'd4000,   2'd0, 2'd1, 3'd3, 1'b1));
    press("f_step4",   STEP, mk(2'd0, 20'd4000,   2'd0, 2'd1, 3'd4, 1'b0));
    press("f_step5",   STEP, mk(2'd0, 20'd4000,   2'd0, 2'd1, 3'd5, 1'b0));
    press("f_dn_sat",  DOWN, mk(2'd0, 20'd1,      2'd0, 2'd1, 3'd5, 1'b1));
    press("f_dn_min",  DOWN, mk(2'd0, 20'd1,      2'd0, 2'd1, 3'd5, 1'b0));
    press("f_up_big",  UP,   mk(2'd0, 20'd100001, 2'd0, 2'd1, 3'd5, 1'b1));
    press("f_stepwrap",STEP, mk(2'd0, 20'd100001, 2'd0, 2'd1, 3'd0, 1'b0));
    press("f_dn1",     DOWN, mk(2'd0, 20'd100000, 2'd0, 2'd1, 3'd0, 1'b1));

    // AMP field: up+down together, only up acts; saturation at 3
    press("mode_amp",  MODE,      mk(2'd0, 20'd100000, 2'd0, 2'd2, 3'd0, 1'b0));
    press("a_updn",    UP | DOWN, mk(2'd0, 20'd100000, 2'd1, 2'd2, 3'd0, 1'b1));
    press("a_up2",     UP,        mk(2'd0, 20'd100000, 2'd2, 2'd2, 3'd0, 1'b1));
    press("a_up3",     UP,        mk(2'd0, 20'd100000, 2'd3, 2'd2, 3'd0, 1'b1));
    press("a_sat1",    UP,        mk(2'd0, 20'd100000, 2'd3, 2'd2, 3'd0, 1'b0));
    press("a_sat2",    UP,        mk(2'd0, 20'd100000, 2'd3, 2'd2, 3'd0, 1'b0));
    press("a_step",    STEP,      mk(2'd0, 20'd100000, 2'd3, 2'd2, 3'd0, 1'b0));
    press("a_dn",      DOWN,      mk(2'd0, 20'd100000, 2'd2, 2'd2, 3'd0, 1'b1));

    // Back to WAVE: down wraps 0->3, step ignored, step beats up
    press("mode_wave", MODE,      mk(2'd0, 20'd100000, 2'd2, 2'd0, 3'd0, 1'b0));
    press("w_dnwrap",  DOWN,      mk(2'd3, 20'd100000, 2'd2, 2'd0, 3'd0, 1'b1));
    press("w_upwrap",  UP,        mk(2'd0, 20'd100000, 2'd2, 2'd0, 3'd0, 1'b1));
    press("w_step",    STEP,      mk(2'd0, 20'd100000, 2'd2, 2'd0, 3'd0, 1'b0));
    press("w_stepup",  STEP | UP, mk(2'd0, 20'd100000, 2'd2, 2'd0, 3'd0, 1'b0));
    press("w_modeup",  MODE | UP, mk(2'd0, 20'd100000, 2'd2, 2'd1, 3'd0, 1'b0));

    // Hold up for 100 cycles in FREQ, step_idx=0
    @(posedge clk); #1 key = ~UP;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk); #1;
      exp_hold = 100000;
      if (e >= DEB_CNT + 3) exp_hold += 1;
`ifdef DDS_KEY_AUTO_REPEAT_EN
      if (e >= DEB_CNT + 3 + REP_DLY) exp_hold += 1 + (e - (DEB_CNT + 3 + REP_DLY)) / REP_PER;
`endif
      check("hold_freq", 32'(wave_freq), 32'(exp_hold));
    end
    key = '1;
    repeat (20) @(posedge clk);
`ifdef DDS_KEY_AUTO_REPEAT_EN
    freq_after_hold = 100007;
`else
    freq_after_hold = 100001;
`endif
    #1 check("hold_final", 32'(wave_freq), 32'(freq_after_hold));

    press("f_stepup", STEP | UP, mk(2'd0, 20'(freq_after_hold),      2'd2, 2'd1, 3'd1, 1'b0));
    press("f_up10",   UP,        mk(2'd0, 20'(freq_after_hold + 10), 2'd2, 2'd1, 3'd1, 1'b1));

    // Reset mid-debounce discards the pending press
    @(posedge clk); #1 key = ~UP;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    key = '1;
    @(posedge clk); #1 rst = 1'b0;
    check_state("mid_rst", mk(2'd0, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 check("post_rst_upd", 32'(cfg_upd), 32'd0);
    end
    check_state("post_rst", mk(2'd0, 20'd1000, 2'd0, 2'd0, 3'd0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
